// File: rtl/ahb_lite_interconnect_dec.sv
// rtl/ahb_lite_interconnect_dec.sv - AHB-Lite address decoder, default error subordinate and response mux (optional AHB_DEC_ERR_LOG_EN error log)
module ahb_lite_interconnect_dec #(
    parameter int ADDR_WIDTH            = 32,
    parameter int DATA_WIDTH            = 32,
    parameter int NO_OF_SUBORDINATES    = 3,
    parameter int BITS_FOR_SUBORDINATES = 3
) (
    input  logic                                     HCLK,
    input  logic                                     HRESET,
    input  logic [ADDR_WIDTH-1:0]                    HADDR,
    input  logic [1:0]                               HTRANS,
    output logic [NO_OF_SUBORDINATES-1:0]            HSEL,
    output logic                                     HSEL_DEF,
    input  logic [NO_OF_SUBORDINATES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NO_OF_SUBORDINATES-1:0]            HREADYOUT_S,
    input  logic [NO_OF_SUBORDINATES-1:0]            HRESP_S,
    output logic [DATA_WIDTH-1:0]                    HRDATA,
    output logic                                     HREADY,
    output logic                                     HRESP
`ifdef AHB_DEC_ERR_LOG_EN
    ,
    output logic [15:0]                              ERR_CNT,
    output logic [ADDR_WIDTH-1:0]                    ERR_ADDR
`endif
);

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } def_state_t;

    logic [BITS_FOR_SUBORDINATES-1:0] idx;
    logic [NO_OF_SUBORDINATES-1:0]    dsel_sub;
    logic                             dsel_def;
    def_state_t                       state;
    def_state_t                       state_nxt;
    logic                             def_ready;
    logic                             def_resp;
    logic                             def_start;

    assign idx       = HADDR[ADDR_WIDTH-1 -: BITS_FOR_SUBORDINATES];
    // Only active transfers (NONSEQ/SEQ) into the unmapped region earn an ERROR.
    assign def_start = HSEL_DEF && HTRANS[1];

    // Address-phase decode: region 0 and regions above the last subordinate fall to the default.
    always_comb begin
        HSEL = '0;
        for (int i = 0; i < NO_OF_SUBORDINATES; i++) begin
            if (idx == BITS_FOR_SUBORDINATES'(i + 1)) begin
                HSEL[i] = 1'b1;
            end
        end
        HSEL_DEF = ~|HSEL;
    end

    // Data-phase owner: follows the decode whenever the bus is ready, frozen during wait states.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel_sub <= '0;
            dsel_def <= 1'b1;
        end else if (HREADY) begin
            dsel_sub <= HSEL;
            dsel_def <= HSEL_DEF;
        end
    end

    // Default subordinate state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_OK;
        end else begin
            state <= state_nxt;
        end
    end

    // Default subordinate response, a pure function of state so it cannot loop through HREADY.
    always_comb begin
        def_ready = 1'b1;
        def_resp  = 1'b0;
        case (state)
            ST_ERR1: begin
                def_ready = 1'b0;
                def_resp  = 1'b1;
            end
            ST_ERR2: begin
                def_ready = 1'b1;
                def_resp  = 1'b1;
            end
            default: begin
                def_ready = 1'b1;
                def_resp  = 1'b0;
            end
        endcase
    end

    // Default subordinate next state: two-cycle ERROR, chained when another bad transfer follows.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_OK:   if (HREADY && def_start) state_nxt = ST_ERR1;
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = def_start ? ST_ERR1 : ST_OK;
            default: state_nxt = ST_OK;
        endcase
    end

    // Response mux back to the manager, steered by the registered data-phase owner.
    always_comb begin
        HRDATA = '0;
        HREADY = def_ready;
        HRESP  = def_resp;
        for (int i = 0; i < NO_OF_SUBORDINATES; i++) begin
            if (dsel_sub[i]) begin
                HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
            end
        end
    end

`ifdef AHB_DEC_ERR_LOG_EN
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  trans_unused;

    assign trans_unused = HTRANS[0];

    // Error log: address of the data-phase transfer, counted when its ERROR completes.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_q   <= '0;
            ERR_CNT  <= '0;
            ERR_ADDR <= '0;
        end else if (HREADY) begin
            addr_q <= HADDR;
            if (HRESP) begin
                if (ERR_CNT != 16'hFFFF) begin
                    ERR_CNT <= ERR_CNT + 16'd1;
                end
                ERR_ADDR <= addr_q;
            end
        end
    end
`else
    logic addr_unused;

    assign addr_unused = ^{HADDR[ADDR_WIDTH-BITS_FOR_SUBORDINATES-1:0], HTRANS[0]};
`endif

endmodule
